// File: rtl/x_reg.sv
// Loadable word register for the calculator datapath.
// Captures `in` on the falling edge of clk when `w` is high. The reset is synchronous and active-low.
module x_reg #(
  parameter int unsigned       WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             w,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_out;

  // Reset has priority over a write on the same edge, and the write data is dropped.
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_out <= RESET_VALUE;
    end else if (w) begin
      r_out <= in;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_x_reg.sv
// Directed bench for x_reg: checks reset priority, write, hold, edge sensitivity and bit patterns.
// Inputs change while clk is high, so they are stable at the falling edge. Outputs are sampled 1ns after an edge.
module tb_x_reg;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        w;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;

  x_reg #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .w   (w),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs are applied shortly after a rising edge. One falling edge then follows, and out is sampled.
  task automatic cyc(input logic r, input logic we, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst = r;
    w   = we;
    in  = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    w   = 1'b0;
    in  = 16'h0000;

    cyc(1'b0, 1'b1, 16'h6AB3);
    chk("reset_over_write", out, 16'h0000);

    cyc(1'b1, 1'b1, 16'h6AB3);
    chk("write_6ab3", out, 16'h6AB3);

    cyc(1'b1, 1'b1, 16'h0001);
    chk("overwrite_0001", out, 16'h0001);

    cyc(1'b1, 1'b1, 16'hFFFF);
    chk("all_ones", out, 16'hFFFF);

    cyc(1'b1, 1'b0, 16'h95CD);
    chk("hold_w0", out, 16'hFFFF);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 16'h1234 + 16'(i));
      chk("hold_multi", out, 16'hFFFF);
    end

    // Change the inputs while clk is high. Out must not move before the falling edge.
    @(posedge clk);
    #1;
    w  = 1'b1;
    in = 16'h5A5A;
    #2;
    chk("no_async_in", out, 16'hFFFF);

    // Rising edge only: arm a write while clk is low, then check after the rising edge.
    @(negedge clk);
    #1;
    w  = 1'b1;
    in = 16'hC3C3;
    @(posedge clk);
    #1;
    chk("rise_no_change", out, 16'h5A5A);
    @(negedge clk);
    #1;
    chk("fall_loads", out, 16'hC3C3);

    // Assert reset between edges. It only takes effect at the next falling edge.
    @(posedge clk);
    #1;
    rst = 1'b0;
    w   = 1'b0;
    #2;
    chk("no_async_rst", out, 16'hC3C3);
    @(negedge clk);
    #1;
    chk("reset_w0", out, 16'h0000);

    cyc(1'b1, 1'b1, 16'hA5A5);
    chk("release_write", out, 16'hA5A5);

    cyc(1'b1, 1'b1, 16'h0000);
    chk("write_zeros", out, 16'h0000);

    cyc(1'b1, 1'b1, 16'h8000);
    chk("write_msb", out, 16'h8000);

    cyc(1'b0, 1'b1, 16'h7FFF);
    chk("reset_again", out, 16'h0000);

    cyc(1'b0, 1'b0, 16'hFFFF);
    chk("reset_held", out, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
